// File: rtl/sobel_pkg.sv
// Shared definitions for the Sobel/Canny edge pipeline: direction codes,
// the non-maximum-suppression state encoding and default widths.
package sobel_pkg;

  localparam int MAGW_DEF = 8;

  localparam logic [7:0] DIR_V0   = 8'd0;
  localparam logic [7:0] DIR_H    = 8'd64;
  localparam logic [7:0] DIR_D45  = 8'd128;
  localparam logic [7:0] DIR_V    = 8'd192;
  localparam logic [7:0] DIR_D135 = 8'd255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } nms_state_e;

endpackage

// File: rtl/nms_line_buffer.sv
// Two cascaded one-row delays for the NMS window. Each row is a (W-1)-entry
// RAM with a registered read, giving a total delay of exactly W accepted beats.
module nms_line_buffer #(
  parameter int IMG_WIDTH = 512,
  parameter int MAGW      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [MAGW-1:0] din_mag,
  input  logic [7:0]      din_dir,
  output logic [MAGW-1:0] tap_a_mag,
  output logic [7:0]      tap_a_dir,
  output logic [MAGW-1:0] tap_b_mag
);

  localparam int DEPTH = IMG_WIDTH - 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW-1:0]     ptr;
  logic [MAGW+7:0]   mem_a [DEPTH];
  logic [MAGW-1:0]   mem_b [DEPTH];
  logic [MAGW+7:0]   rd_a;
  logic [MAGW-1:0]   rd_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  // Read-before-write on the same address; the upper row only ever supplies
  // neighbour magnitudes, so it does not carry the direction code.
  always_ff @(posedge clk) begin
    if (en) begin
      rd_a       <= mem_a[ptr];
      mem_a[ptr] <= {din_mag, din_dir};
      rd_b       <= mem_b[ptr];
      mem_b[ptr] <= rd_a[MAGW+7:8];
    end
  end

  assign tap_a_mag = rd_a[MAGW+7:8];
  assign tap_a_dir = rd_a[7:0];
  assign tap_b_mag = rd_b;

endmodule

// File: rtl/non_max_suppress.sv
// Streaming Canny non-maximum suppression: 3x3 magnitude window, frame FSM
// and the directional local-maximum test. One output per input pixel.
module non_max_suppress
  import sobel_pkg::*;
#(
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 1024,
  parameter int MAGW       = MAGW_DEF,
  parameter int LOW_THRESH = 0,
  parameter int CNTW       = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            startEn,
  input  logic            pixValid,
  input  logic [MAGW-1:0] mag,
  input  logic [7:0]      dirE,
  output logic [MAGW-1:0] edgeOut,
  output logic            outValid,
  output logic            frameDone,
  output logic            busy
);

  localparam logic [CNTW-1:0] FILL_LAST = CNTW'(IMG_WIDTH);
  localparam logic [CNTW-1:0] LAST_IN   = CNTW'(IMG_WIDTH * IMG_HEIGHT - 1);
  localparam logic [CNTW-1:0] LAST_COL  = CNTW'(IMG_WIDTH - 1);
  localparam logic [CNTW-1:0] LAST_ROW  = CNTW'(IMG_HEIGHT - 1);

  nms_state_e      state;
  logic [CNTW-1:0] in_cnt;
  logic [CNTW-1:0] out_col;
  logic [CNTW-1:0] out_row;

  logic            flushing;
  logic            adv;
  logic            emit;
  logic [MAGW-1:0] new_mag;
  logic [7:0]      new_dir;

  assign flushing = (state == ST_FLUSH);
  assign adv      = (((state == ST_FILL) || (state == ST_RUN)) && pixValid) || flushing;
  assign emit     = ((state == ST_RUN) && pixValid) || flushing;
  assign new_mag  = flushing ? '0 : mag;
  assign new_dir  = flushing ? DIR_V0 : dirE;

  logic [MAGW-1:0] tap_a_mag;
  logic [7:0]      tap_a_dir;
  logic [MAGW-1:0] tap_b_mag;

  nms_line_buffer #(
    .IMG_WIDTH (IMG_WIDTH),
    .MAGW      (MAGW)
  ) u_line_buffer (
    .clk       (clk),
    .reset     (reset),
    .en        (adv),
    .din_mag   (new_mag),
    .din_dir   (new_dir),
    .tap_a_mag (tap_a_mag),
    .tap_a_dir (tap_a_dir),
    .tap_b_mag (tap_b_mag)
  );

  // Registers hold the left and centre columns; the right column comes
  // straight from the line-buffer taps and the incoming beat.
  logic [MAGW-1:0] top_reg [2];
  logic [MAGW-1:0] mid_reg [2];
  logic [MAGW-1:0] bot_reg [2];
  logic [7:0]      ctr_dir_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      top_reg     <= '{default: '0};
      mid_reg     <= '{default: '0};
      bot_reg     <= '{default: '0};
      ctr_dir_reg <= '0;
    end else if (adv) begin
      top_reg[0]  <= top_reg[1];
      top_reg[1]  <= tap_b_mag;
      mid_reg[0]  <= mid_reg[1];
      mid_reg[1]  <= tap_a_mag;
      bot_reg[0]  <= bot_reg[1];
      bot_reg[1]  <= new_mag;
      ctr_dir_reg <= tap_a_dir;
    end
  end

  logic [MAGW-1:0] ctr;
  logic [MAGW-1:0] nb_a;
  logic [MAGW-1:0] nb_b;
  logic            dir_ok;
  logic            thr_ok;
  logic            border;
  logic [MAGW-1:0] result;

  always_comb begin
    ctr    = mid_reg[1];
    nb_a   = '0;
    nb_b   = '0;
    dir_ok = 1'b1;
    case (ctr_dir_reg)
      DIR_H:         begin nb_a = mid_reg[0]; nb_b = tap_a_mag;  end
      DIR_D45:       begin nb_a = tap_b_mag;  nb_b = bot_reg[0]; end
      DIR_V0, DIR_V: begin nb_a = top_reg[1]; nb_b = bot_reg[1]; end
      DIR_D135:      begin nb_a = top_reg[0]; nb_b = new_mag;    end
      default:       dir_ok = 1'b0;
    endcase
  end

  if (LOW_THRESH > 0) begin : g_thr
    assign thr_ok = (ctr >= MAGW'(LOW_THRESH));
  end else begin : g_no_thr
    assign thr_ok = 1'b1;
  end

  // Border forcing also hides the row-wrapped neighbours at the first/last column.
  assign border = (out_row == '0) || (out_row == LAST_ROW) ||
                  (out_col == '0) || (out_col == LAST_COL);
  assign result = (dir_ok && thr_ok && !border && (ctr >= nb_a) && (ctr > nb_b)) ? ctr : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      in_cnt    <= '0;
      out_col   <= '0;
      out_row   <= '0;
      edgeOut   <= '0;
      outValid  <= 1'b0;
      frameDone <= 1'b0;
      busy      <= 1'b0;
    end else begin
      outValid  <= emit;
      edgeOut   <= emit ? result : '0;
      frameDone <= 1'b0;
      if (emit) begin
        if (out_col == LAST_COL) begin
          out_col <= '0;
          out_row <= out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end
      case (state)
        ST_IDLE: begin
          if (startEn) begin
            state   <= ST_FILL;
            busy    <= 1'b1;
            in_cnt  <= '0;
            out_col <= '0;
            out_row <= '0;
          end
        end
        ST_FILL: begin
          if (pixValid) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == FILL_LAST) state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (pixValid) begin
            in_cnt <= in_cnt + 1'b1;
            if (in_cnt == LAST_IN) state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if ((out_row == LAST_ROW) && (out_col == LAST_COL)) state <= ST_DONE;
        end
        ST_DONE: begin
          frameDone <= 1'b1;
          busy      <= 1'b0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_non_max_suppress.sv
// Bench for non_max_suppress on an 8x4 frame: hand-derived vectors, random
// frames against a pixel-level reference, plus reset/start corner sequences.
module tb_non_max_suppress;

  localparam int W = 8;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk;
  logic       reset;
  logic       startEn;
  logic       pixValid;
  logic [7:0] mag;
  logic [7:0] dirE;
  logic [7:0] edge0, edge1;
  logic       valid0, valid1, done0, done1, busy0, busy1;

  non_max_suppress #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAGW(8), .LOW_THRESH(0), .CNTW(24)) dut0 (
    .clk(clk), .reset(reset), .startEn(startEn), .pixValid(pixValid), .mag(mag), .dirE(dirE),
    .edgeOut(edge0), .outValid(valid0), .frameDone(done0), .busy(busy0));

  non_max_suppress #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .MAGW(8), .LOW_THRESH(25), .CNTW(24)) dut1 (
    .clk(clk), .reset(reset), .startEn(startEn), .pixValid(pixValid), .mag(mag), .dirE(dirE),
    .edgeOut(edge1), .outValid(valid1), .frameDone(done1), .busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int img_mag [N];
  int img_dir [N];
  int exp0 [N];
  int exp25 [N];
  int q0 [$];
  int q1 [$];
  int fd_cnt0 = 0;
  int spurious = 0;
  int frames_run = 0;
  bit in_phase = 0;
  bit pv_prev = 0;

  typedef struct {
    string name;
    int bg, bgdir;
    int cr, cc, cm, cd;
    int n1r, n1c, n1m;
    int n2r, n2c, n2m;
    int e0, e25;
  } vec_t;

  vec_t vecs [14];
  int dir_pool [6] = '{0, 64, 128, 192, 255, 17};

  always @(posedge clk) pv_prev <= pixValid;

  always @(negedge clk) begin
    if (valid0) q0.push_back(int'(edge0));
    if (valid1) q1.push_back(int'(edge1));
    if (done0) fd_cnt0++;
    if (in_phase && valid0 && !pv_prev) spurious++;
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic int px(input int r, input int c);
    return img_mag[r * W + c];
  endfunction

  // Reference: straight from the neighbour-pair table and keep rule.
  function automatic int ref_pix(input int r, input int c, input int thr);
    int ctr, a, b;
    if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
    ctr = px(r, c);
    case (img_dir[r * W + c])
      64:      begin a = px(r, c - 1);     b = px(r, c + 1);     end
      128:     begin a = px(r - 1, c + 1); b = px(r + 1, c - 1); end
      0, 192:  begin a = px(r - 1, c);     b = px(r + 1, c);     end
      255:     begin a = px(r - 1, c - 1); b = px(r + 1, c + 1); end
      default: return 0;
    endcase
    return (ctr >= a && ctr > b && ctr >= thr) ? ctr : 0;
  endfunction

  task automatic run_frame(input string tag, input int mode, input bit poke_start);
    int gap;
    bit done;
    q0.delete();
    q1.delete();
    for (int j = 0; j < N; j++) begin
      exp0[j]  = ref_pix(j / W, j % W, 0);
      exp25[j] = ref_pix(j / W, j % W, 25);
    end
    pixValid = 1'b0;
    startEn  = 1'b1;
    @(posedge clk); #1;
    startEn  = 1'b0;
    check("busy_after_start", int'(busy0), 1);
    in_phase = 1'b1;
    for (int k = 0; k < N; k++) begin
      gap = 0;
      if (mode == 1 && k > 0) gap = 1;
      if (mode == 2) gap = ($urandom_range(0, 2) == 0) ? 1 : 0;
      while (gap > 0) begin
        pixValid = 1'b0;
        mag      = 8'($urandom_range(0, 255));
        dirE     = 8'd64;
        @(posedge clk); #1;
        gap--;
      end
      pixValid = 1'b1;
      mag      = 8'(img_mag[k]);
      dirE     = 8'(img_dir[k]);
      startEn  = poke_start && (k == N / 2);
      @(posedge clk); #1;
    end
    startEn  = 1'b0;
    in_phase = 1'b0;
    done     = 1'b0;
    // Junk beats during flush/idle must be dropped.
    for (int t = 0; t < 200 && !done; t++) begin
      pixValid = 1'($urandom_range(0, 1));
      mag      = 8'($urandom_range(0, 255));
      dirE     = 8'(dir_pool[$urandom_range(0, 5)]);
      @(negedge clk); #1;
      if (done0) begin
        done = 1'b1;
        check("busy_at_done", int'(busy0), 0);
      end
    end
    pixValid = 1'b0;
    frames_run++;
    check("frame_done_seen", int'(done), 1);
    check("outputs_thr0", q0.size(), N);
    check("outputs_thr25", q1.size(), N);
    for (int j = 0; j < N; j++) begin
      if (j < q0.size()) check($sformatf("%s_px%0d_thr0", tag, j), q0[j], exp0[j]);
      if (j < q1.size()) check($sformatf("%s_px%0d_thr25", tag, j), q1[j], exp25[j]);
    end
    $display("frame %0d [%s] mode %0d: %0d/%0d outputs, %0d mismatched so far",
             frames_run, tag, mode, q0.size(), N, n_bad);
  endtask

  task automatic load_vec(input vec_t v);
    for (int j = 0; j < N; j++) begin
      img_mag[j] = v.bg;
      img_dir[j] = v.bgdir;
    end
    img_mag[v.cr * W + v.cc] = v.cm;
    img_dir[v.cr * W + v.cc] = v.cd;
    if (v.n1m >= 0) img_mag[(v.cr + v.n1r) * W + v.cc + v.n1c] = v.n1m;
    if (v.n2m >= 0) img_mag[(v.cr + v.n2r) * W + v.cc + v.n2c] = v.n2m;
  endtask

  task automatic random_image();
    for (int j = 0; j < N; j++) begin
      img_mag[j] = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7) * 5;
      img_dir[j] = dir_pool[$urandom_range(0, 5)];
    end
  endtask

  initial begin
    vecs[0]  = '{"flat10_d64",   10, 64,  1, 3, 10, 64,   0,  0, -1,  0,  0, -1,  0,  0};
    vecs[1]  = '{"peak50_d64",   20, 64,  1, 3, 50, 64,   0,  0, -1,  0,  0, -1, 50, 50};
    vecs[2]  = '{"peak50_d192",  20, 64,  1, 3, 50, 192, -1,  0, 60,  1,  0, 60,  0,  0};
    vecs[3]  = '{"diag255",       0,  0,  2, 2, 40, 255, -1, -1, 30,  1,  1, 39, 40, 40};
    vecs[4]  = '{"diag128_ur41",  0,  0,  2, 2, 40, 128, -1,  1, 41,  1, -1, 30,  0,  0};
    vecs[5]  = '{"dir17",         0,  0,  2, 2, 40, 17,  -1, -1, 30,  0,  0, -1,  0,  0};
    vecs[6]  = '{"peak20_thr",    0, 64,  2, 4, 20, 64,   0,  0, -1,  0,  0, -1, 20,  0};
    vecs[7]  = '{"peak25_thr",    0, 64,  1, 5, 25, 64,   0,  0, -1,  0,  0, -1, 25, 25};
    vecs[8]  = '{"tie_left",      0, 64,  1, 2, 30, 64,   0, -1, 30,  0,  0, -1, 30, 30};
    vecs[9]  = '{"tie_right",     0, 64,  1, 2, 30, 64,   0,  1, 30,  0,  0, -1,  0,  0};
    vecs[10] = '{"border_row0",   0, 64,  0, 3, 99, 64,   0,  0, -1,  0,  0, -1,  0,  0};
    vecs[11] = '{"border_col7",   0, 64,  2, 7, 99, 64,   0,  0, -1,  0,  0, -1,  0,  0};
    vecs[12] = '{"diag128_tie",   0,  0,  2, 3, 40, 128, -1,  1, 40,  1, -1, 39, 40, 40};
    vecs[13] = '{"vert0",         0,  0,  1, 4, 33, 0,   -1,  0, 33,  1,  0, 32, 33, 33};

    reset    = 1'b0;
    startEn  = 1'b0;
    pixValid = 1'b0;
    mag      = '0;
    dirE     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_edgeOut", int'(edge0), 0);
    check("reset_outValid", int'(valid0), 0);
    check("reset_frameDone", int'(done0), 0);
    check("reset_busy", int'(busy0), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int v = 0; v < 14; v++) begin
      load_vec(vecs[v]);
      run_frame(vecs[v].name, v % 3, 1'b0);
      if (q0.size() == N)
        check({vecs[v].name, "_centre_thr0"}, q0[vecs[v].cr * W + vecs[v].cc], vecs[v].e0);
      if (q1.size() == N)
        check({vecs[v].name, "_centre_thr25"}, q1[vecs[v].cr * W + vecs[v].cc], vecs[v].e25);
    end

    for (int f = 0; f < 6; f++) begin
      random_image();
      run_frame($sformatf("rand%0d", f), f % 3, f == 4);
      if (f == 0) run_frame("rand0_toggle", 1, 1'b0);
    end

    // Abort mid-RUN while an output is valid.
    random_image();
    q0.delete();
    q1.delete();
    startEn = 1'b1;
    @(posedge clk); #1;
    startEn = 1'b0;
    for (int k = 0; k < W + 4; k++) begin
      pixValid = 1'b1;
      mag      = 8'(img_mag[k]);
      dirE     = 8'(img_dir[k]);
      @(posedge clk); #1;
    end
    check("pre_reset_outValid", int'(valid0), 1);
    #1 reset = 1'b0;
    #1;
    check("abort_edgeOut", int'(edge0), 0);
    check("abort_outValid", int'(valid0) + int'(valid1), 0);
    check("abort_busy", int'(busy0) + int'(busy1), 0);
    q0.delete();
    q1.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 20; k++) begin
      pixValid = 1'b1;
      mag      = 8'($urandom_range(0, 255));
      dirE     = 8'd64;
      @(posedge clk); #1;
    end
    pixValid = 1'b0;
    @(negedge clk); #1;
    check("no_output_without_start", q0.size() + q1.size(), 0);
    check("idle_busy_after_abort", int'(busy0), 0);

    load_vec(vecs[1]);
    run_frame("after_abort", 0, 1'b0);

    repeat (5) @(posedge clk);
    #1;
    check("frameDone_total", fd_cnt0, frames_run);
    check("spurious_outValid", spurious, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
